ahb_apb_bridge_ctrl: RTL and testbench

Parametrised AHB-to-APB bridge controller, successor to the fixed 3-slave, 32-bit bridge FSM. Sits between the AHB slave-interface pipeline and the APB bus.
- Accepts one AHB transfer at a time.
- Decodes a one-hot PSEL over NUM_SLV slaves.
- Runs APB SETUP/ACCESS with PREADY wait states.
- Returns PSLVERR, decode errors and timeouts to AHB as a two-cycle ERROR response.

---
 rtl/ahb_apb_pkg.sv | 22 ++
 rtl/apb_sel_decode.sv | 22 ++
 rtl/ahb_apb_bridge_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ahb_apb_bridge_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-to-APB bridge controller.
// Used by ahb_apb_bridge_ctrl and apb_sel_decode.
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WWAIT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Width of a counter that must reach max_cnt-1; never narrower than one bit.
    function automatic int cnt_width(input int unsigned max_cnt);
        return (max_cnt < 32'd2) ? 1 : $clog2(max_cnt);
    endfunction

endpackage

// File: rtl/apb_sel_decode.sv
// Slave-index to one-hot PSEL decoder with out-of-range flag.
module apb_sel_decode #(
    parameter int NUM_SLV = 6,
    parameter int SEL_W   = 3
) (
    input  logic [SEL_W-1:0]   idx,
    output logic [NUM_SLV-1:0] sel,
    output logic               oor
);

    localparam int SW1 = SEL_W + 1;
    localparam logic [SEL_W:0] NUM_SLV_C = SW1'(NUM_SLV);

    // An out-of-range index matches no slave, so sel stays all-zero for it.
    always_comb begin
        oor = ({1'b0, idx} >= NUM_SLV_C);
        for (int i = 0; i < NUM_SLV; i++) begin
            sel[i] = (idx == SEL_W'(i));
        end
    end

endmodule

// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-to-APB bridge controller: one transfer at a time, one-hot PSEL, two-cycle ERROR.
// Optional macro WR_POST_EN: posted writes with a one-deep hold of the next transfer.
module ahb_apb_bridge_ctrl
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 6,
    parameter int SEL_LSB = 12,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 0
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               VALID,
    input  logic               HREADY,
    input  logic               HWRITE,
    input  logic [ADDR_W-1:0]  HADDR,
    input  logic [DATA_W-1:0]  HWDATA,
    output logic               HREADYOUT,
    output logic               HRESP,
    output logic [DATA_W-1:0]  HRDATA,
    output logic [NUM_SLV-1:0] PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [ADDR_W-1:0]  PADDR,
    output logic [DATA_W-1:0]  PWDATA,
    input  logic [DATA_W-1:0]  PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e               state_r, nxt_s, start_nxt_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [NUM_SLV-1:0]   sel_r, sel_s, dec_sel_s, psel_s;
    logic                 accept_s, free_s, start_s, done_s, tmo_s, slv_err_s, oor_s;
    logic                 start_wr_s, hreadyout_s, hresp_s, penable_s, pwrite_s;
    logic [ADDR_W-1:0]    start_addr_s, paddr_s;
    logic [DATA_W-1:0]    pwdata_s, hrdata_s;
`ifdef WR_POST_EN
    logic                 pend_r, pend_s, pend_wr_r, post_err_r;
    logic [ADDR_W-1:0]    pend_addr_r;
`endif

    apb_sel_decode #(.NUM_SLV(NUM_SLV), .SEL_W(SEL_W)) u_sel_decode (
        .idx (start_addr_s[SEL_LSB +: SEL_W]),
        .sel (dec_sel_s),
        .oor (oor_s)
    );

    // Transfer start/completion qualifiers shared by the FSM and datapath.
    always_comb begin
        accept_s  = VALID & HREADY & HREADYOUT;
        free_s    = (state_r == ST_IDLE) || (state_r == ST_ERR2);
        tmo_s     = (TIMEOUT != 0) && (state_r == ST_ACCESS) && !PREADY && (cnt_r == TMO_LAST);
        done_s    = (state_r == ST_ACCESS) && (PREADY || tmo_s);
        slv_err_s = (PREADY & PSLVERR) | tmo_s;
`ifdef WR_POST_EN
        // A held transfer starts as soon as the posted write in flight retires.
        start_s      = (free_s && accept_s) || (done_s && (pend_r || accept_s));
        start_addr_s = pend_r ? pend_addr_r : HADDR;
        start_wr_s   = pend_r ? pend_wr_r : HWRITE;
        pend_s       = pend_r ? !start_s : (accept_s && !free_s && !done_s);
`else
        start_s      = free_s && accept_s;
        start_addr_s = HADDR;
        start_wr_s   = HWRITE;
`endif
    end

    // State register and ACCESS wait counter.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            sel_r   <= '0;
        end else begin
            state_r <= nxt_s;
            sel_r   <= sel_s;
            if (nxt_s == ST_SETUP) begin
                cnt_r <= '0;
            end else if ((state_r == ST_ACCESS) && !PREADY) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        start_nxt_s = oor_s ? ST_ERR1 : (start_wr_s ? ST_WWAIT : ST_SETUP);
        nxt_s       = state_r;
        case (state_r)
            ST_IDLE, ST_ERR2: nxt_s = start_s ? start_nxt_s : ST_IDLE;
            ST_WWAIT:         nxt_s = ST_SETUP;
            ST_SETUP:         nxt_s = ST_ACCESS;
            ST_ACCESS: begin
`ifdef WR_POST_EN
                if (!done_s) begin
                    nxt_s = ST_ACCESS;
                end else if (slv_err_s && !PWRITE) begin
                    nxt_s = ST_ERR1;
                end else begin
                    nxt_s = start_s ? start_nxt_s : ST_IDLE;
                end
`else
                if (!done_s) begin
                    nxt_s = ST_ACCESS;
                end else begin
                    nxt_s = slv_err_s ? ST_ERR1 : ST_IDLE;
                end
`endif
            end
            ST_ERR1:          nxt_s = ST_ERR2;
            default:          nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered bus outputs, derived from the next state.
    always_comb begin
        sel_s     = start_s ? dec_sel_s : sel_r;
        psel_s    = ((nxt_s == ST_SETUP) || (nxt_s == ST_ACCESS)) ? sel_s : '0;
        penable_s = (nxt_s == ST_ACCESS);
        if (start_s && !oor_s) begin
            paddr_s  = start_addr_s;
            pwrite_s = start_wr_s;
        end else begin
            paddr_s  = PADDR;
            pwrite_s = PWRITE;
        end
        pwdata_s = (state_r == ST_WWAIT) ? HWDATA : PWDATA;
        hrdata_s = ((state_r == ST_ACCESS) && PREADY && !PSLVERR && !PWRITE) ? PRDATA : HRDATA;
        hresp_s  = ((nxt_s == ST_ERR1) || (nxt_s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`ifdef WR_POST_EN
        hreadyout_s = (nxt_s == ST_IDLE) || (nxt_s == ST_ERR2) ||
                      (((nxt_s == ST_WWAIT) || (nxt_s == ST_SETUP) || (nxt_s == ST_ACCESS)) &&
                       pwrite_s && !pend_s);
`else
        hreadyout_s = (nxt_s == ST_IDLE) || (nxt_s == ST_ERR2);
`endif
    end

    // Output registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            HRDATA    <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
        end else begin
            HREADYOUT <= hreadyout_s;
            HRESP     <= hresp_s;
            HRDATA    <= hrdata_s;
            PSEL      <= psel_s;
            PENABLE   <= penable_s;
            PWRITE    <= pwrite_s;
            PADDR     <= paddr_s;
            PWDATA    <= pwdata_s;
        end
    end

`ifdef WR_POST_EN
    // Held transfer behind a posted write, and sticky posted-write error flag.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_r      <= 1'b0;
            pend_wr_r   <= 1'b0;
            pend_addr_r <= '0;
            post_err_r  <= 1'b0;
        end else begin
            pend_r <= pend_s;
            if (accept_s && !free_s && !done_s) begin
                pend_addr_r <= HADDR;
                pend_wr_r   <= HWRITE;
            end
            if (done_s && slv_err_s && PWRITE) begin
                post_err_r <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// Self-checking bench for ahb_apb_bridge_ctrl (default build, TIMEOUT=4).
module tb_ahb_apb_bridge_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 6;
    localparam int SL = 12;
    localparam int SW = 3;
    localparam int TO = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          VALID, HREADY, HWRITE;
    logic [AW-1:0] HADDR;
    logic [DW-1:0] HWDATA;
    logic          HREADYOUT, HRESP;
    logic [DW-1:0] HRDATA;
    logic [NS-1:0] PSEL;
    logic          PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] exp_hrdata = '0;

    always #5 HCLK = ~HCLK;

    ahb_apb_bridge_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .SEL_LSB(SL), .SEL_W(SW), .TIMEOUT(TO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .VALID(VALID), .HREADY(HREADY), .HWRITE(HWRITE),
        .HADDR(HADDR), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hreadyout"}, HREADYOUT, 1);
        check({tag, "_hresp"},     HRESP,     0);
        check({tag, "_hrdata"},    HRDATA,    0);
        check({tag, "_psel"},      PSEL,      0);
        check({tag, "_penable"},   PENABLE,   0);
        check({tag, "_pwrite"},    PWRITE,    0);
        check({tag, "_paddr"},     PADDR,     0);
        check({tag, "_pwdata"},    PWDATA,    0);
    endtask

    task automatic drive_addr(input logic [AW-1:0] a, input logic w);
        VALID  = 1'b1;
        HREADY = 1'b1;
        HADDR  = a;
        HWRITE = w;
    endtask

    // Runs one transfer whose address phase is already on the bus; expectations come
    // from the transfer-level rules (wait-cycle counts, error length, selected slave).
    task automatic run_xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                            input int waits, input logic serr, input logic [DW-1:0] rd,
                            input logic chain, input logic [AW-1:0] next_a);
        int            idx, acc, exp_low, exp_resp;
        int            low, resp, pen, cyc;
        logic          oor, err, done, bad_sel, bad_addr, bad_wd;
        logic [NS-1:0] exp_sel;
        idx     = int'(a[SL +: SW]);
        oor     = (idx >= NS);
        exp_sel = '0;
        if (!oor) exp_sel[idx] = 1'b1;
        acc      = oor ? 0 : ((waits >= TO) ? TO : waits + 1);
        err      = oor || (waits >= TO) || serr;
        exp_low  = oor ? 1 : (w ? 1 : 0) + 1 + acc + (err ? 1 : 0);
        exp_resp = err ? 2 : 0;
        low = 0; resp = 0; pen = 0; cyc = 0;
        done = 1'b0; bad_sel = 1'b0; bad_addr = 1'b0; bad_wd = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge HCLK);
            cyc++;
            HWDATA = (cyc == 1) ? wd : $urandom;
            if (!HREADYOUT) low++;
            if (HRESP) resp++;
            if (PENABLE) pen++;
            if (cyc == 1) begin
                check("first_psel", PSEL, (w || oor) ? '0 : exp_sel);
                check("first_hresp", HRESP, oor);
            end
            if (PSEL != '0) begin
                if (PSEL !== exp_sel || HRESP) bad_sel = 1'b1;
                if (PADDR !== a || PWRITE !== w) bad_addr = 1'b1;
            end
            if (PENABLE && w && PWDATA !== wd) bad_wd = 1'b1;
            if (PENABLE) begin
                PREADY  = (pen - 1 == waits);
                PSLVERR = PREADY ? serr : 1'($urandom);
                PRDATA  = PREADY ? rd : $urandom;
            end else begin
                PREADY  = 1'($urandom);
                PSLVERR = 1'($urandom);
                PRDATA  = $urandom;
            end
            VALID = 1'b0;
            if (!HREADYOUT) begin
                VALID  = 1'($urandom);
                HREADY = 1'($urandom);
                HWRITE = 1'($urandom);
                HADDR  = $urandom;
            end
            if (HREADYOUT && HRESP && chain) begin
                drive_addr(next_a, 1'b0);
                done = 1'b1;
            end else if (HREADYOUT && !HRESP) begin
                done = 1'b1;
            end
        end
        check("xfer_completed", done, 1);
        if (!w && !err) exp_hrdata = rd;
        check("hreadyout_low_cycles", low, exp_low);
        check("hresp_error_cycles", resp, exp_resp);
        check("penable_cycles", pen, acc);
        check("psel_onehot", bad_sel, 0);
        check("paddr_pwrite", bad_addr, 0);
        check("pwdata_stable", bad_wd, 0);
        check("hrdata", HRDATA, exp_hrdata);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        logic [AW-1:0] a;
        HRESETn = 1'b0; VALID = 1'b0; HREADY = 1'b1; HWRITE = 1'b0;
        HADDR = '0; HWDATA = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (3) @(negedge HCLK);
        check_reset_vals("reset");
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Zero-wait read from slave 2.
        drive_addr(32'h0000_2004, 1'b0);
        run_xfer(32'h0000_2004, 1'b0, '0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, '0);
        check("read_data_deadbeef", HRDATA, 32'hDEAD_BEEF);

        // Write to slave 0 with three PREADY-low cycles.
        drive_addr(32'h0000_0010, 1'b1);
        run_xfer(32'h0000_0010, 1'b1, 32'hA5A5_A5A5, 3, 1'b0, '0, 1'b0, '0);
        check("write_pwdata", PWDATA, 32'hA5A5_A5A5);

        // Out-of-range slave index.
        drive_addr(32'h0000_7000, 1'b0);
        run_xfer(32'h0000_7000, 1'b0, '0, 0, 1'b0, '0, 1'b0, '0);

        // Slave error on a write, then a read accepted in the second ERROR cycle.
        drive_addr(32'h0000_3008, 1'b1);
        run_xfer(32'h0000_3008, 1'b1, 32'h1234_5678, 0, 1'b1, '0, 1'b1, 32'h0000_4000);
        run_xfer(32'h0000_4000, 1'b0, '0, 1, 1'b0, 32'h0BAD_F00D, 1'b0, '0);

        // PREADY never arrives: timeout.
        drive_addr(32'h0000_5000, 1'b0);
        run_xfer(32'h0000_5000, 1'b0, '0, 9, 1'b0, '0, 1'b0, '0);
        check("timeout_psel_dropped", PSEL, 0);

        // Asynchronous reset in the middle of ACCESS.
        drive_addr(32'h0000_1010, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge HCLK);
            VALID  = 1'b0;
            PREADY = 1'b0;
            if (PENABLE) found = 1'b1;
        end
        check("reached_access", found, 1);
        #2 HRESETn = 1'b0;
        #1 check_reset_vals("async_reset");
        @(negedge HCLK);
        HRESETn = 1'b1;
        exp_hrdata = '0;
        @(negedge HCLK);
        drive_addr(32'h0000_1020, 1'b0);
        run_xfer(32'h0000_1020, 1'b0, '0, 0, 1'b0, 32'hC0FF_EE00, 1'b0, '0);

        // Randomized transfers.
        for (int n = 0; n < 40; n++) begin
            logic          w, serr;
            int            waits;
            logic [DW-1:0] wd, rd;
            if ($urandom_range(0, 3) == 0) begin
                VALID  = 1'b1;
                HREADY = 1'b0;
                HADDR  = $urandom;
                @(negedge HCLK);
                check("no_accept_hready_low", {HREADYOUT, PSEL, HRESP}, {1'b1, {NS{1'b0}}, 1'b0});
            end
            a     = {$urandom_range(0, 15), 3'($urandom_range(0, 7)), 12'($urandom)};
            w     = 1'($urandom);
            waits = $urandom_range(0, 5);
            serr  = ($urandom_range(0, 5) == 0);
            wd    = $urandom;
            rd    = $urandom;
            drive_addr(a, w);
            run_xfer(a, w, wd, waits, serr, rd, 1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
